// File: rtl/ctrl_decode_stage_if.sv
// Handshake/control-word bundle between the ID front end, ctrl_decode_stage and the ID/EXE register.
// master = surrounding pipeline (drives opcode, hazard, flush, out_ready); slave = the decode stage.
interface ctrl_decode_stage_if #(
    parameter int OP_CODE_LEN = 6,
    parameter int EXE_CMD_LEN = 4,
    parameter int CNT_W       = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [OP_CODE_LEN-1:0] opCode;
    logic                   hazard_detected;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic                   branchEn;
    logic [EXE_CMD_LEN-1:0] EXE_CMD;
    logic [1:0]             Branch_command;
    logic                   Is_Imm;
    logic                   ST_or_BNE;
    logic                   WB_EN;
    logic                   MEM_R_EN;
    logic                   MEM_W_EN;
    logic                   illegal_op;
    logic [CNT_W-1:0]       bubble_cnt;

    modport master (
        output in_valid, opCode, hazard_detected, flush, out_ready,
        input  in_ready, out_valid, branchEn, EXE_CMD, Branch_command, Is_Imm,
               ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN, illegal_op, bubble_cnt
    );

    modport slave (
        input  in_valid, opCode, hazard_detected, flush, out_ready,
        output in_ready, out_valid, branchEn, EXE_CMD, Branch_command, Is_Imm,
               ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN, illegal_op, bubble_cnt
    );
endinterface

// File: rtl/ctrl_decode_stage.sv
// Registered ID-stage control decoder, latency 1; 1-entry skid lets it back-pressure decode via in_ready.
// Hazards insert counted NOP bubbles, flush discards output and skid words.
`ifndef OP_CODE_LEN
`define OP_CODE_LEN      6
`define EXE_CMD_LEN      4
`define OP_ADD           6'b000001
`define OP_SUB           6'b000011
`define OP_AND           6'b000101
`define OP_OR            6'b000110
`define OP_NOR           6'b000111
`define OP_XOR           6'b001000
`define OP_SLA           6'b001001
`define OP_SLL           6'b001010
`define OP_SRA           6'b001011
`define OP_SRL           6'b001100
`define OP_ADDI          6'b100000
`define OP_SUBI          6'b100001
`define OP_LD            6'b100100
`define OP_ST            6'b100101
`define OP_BEZ           6'b101000
`define OP_BNE           6'b101001
`define OP_JMP           6'b101010
`define EXE_ADD          4'b0000
`define EXE_SUB          4'b0010
`define EXE_AND          4'b0100
`define EXE_OR           4'b0101
`define EXE_NOR          4'b0110
`define EXE_XOR          4'b0111
`define EXE_SLA          4'b1000
`define EXE_SLL          4'b1000
`define EXE_SRA          4'b1001
`define EXE_SRL          4'b1010
`define EXE_NO_OPERATION 4'b1111
`define COND_JUMP        2'b10
`define COND_BEZ         2'b11
`define COND_BNE         2'b01
`endif

module ctrl_decode_stage #(
    parameter int OP_CODE_LEN      = 6,
    parameter int EXE_CMD_LEN      = 4,
    parameter int CNT_W            = 16,
    parameter int BUBBLE_CLEAR_ALL = 1
) (
    input logic                 clk,
    input logic                 rst,
    ctrl_decode_stage_if.slave  bus
);

    if (OP_CODE_LEN != `OP_CODE_LEN || EXE_CMD_LEN != `EXE_CMD_LEN) begin : g_bad_width
        $error("ctrl_decode_stage: opcode/command widths must match the ISA definitions");
    end

    typedef struct packed {
        logic                   branch_en;
        logic [EXE_CMD_LEN-1:0] exe_cmd;
        logic [1:0]             br_cmd;
        logic                   is_imm;
        logic                   st_or_bne;
        logic                   wb_en;
        logic                   mem_r_en;
        logic                   mem_w_en;
        logic                   illegal;
    } ctrl_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    function automatic ctrl_t nop_word();
        ctrl_t w;
        w         = '0;
        w.exe_cmd = `EXE_NO_OPERATION;
        return w;
    endfunction

    ctrl_t            out_q, out_d;
    ctrl_t            skid_q, skid_d;
    ctrl_t            dec_word;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             slot_free;
    logic             in_ready;
    logic             accept;

    always_comb begin
        dec_word = nop_word();
        case (bus.opCode)
            `OP_ADD:  begin dec_word.exe_cmd = `EXE_ADD; dec_word.wb_en = 1'b1; end
            `OP_SUB:  begin dec_word.exe_cmd = `EXE_SUB; dec_word.wb_en = 1'b1; end
            `OP_AND:  begin dec_word.exe_cmd = `EXE_AND; dec_word.wb_en = 1'b1; end
            `OP_OR:   begin dec_word.exe_cmd = `EXE_OR;  dec_word.wb_en = 1'b1; end
            `OP_NOR:  begin dec_word.exe_cmd = `EXE_NOR; dec_word.wb_en = 1'b1; end
            `OP_XOR:  begin dec_word.exe_cmd = `EXE_XOR; dec_word.wb_en = 1'b1; end
            `OP_SLA:  begin dec_word.exe_cmd = `EXE_SLA; dec_word.wb_en = 1'b1; end
            `OP_SLL:  begin dec_word.exe_cmd = `EXE_SLL; dec_word.wb_en = 1'b1; end
            `OP_SRA:  begin dec_word.exe_cmd = `EXE_SRA; dec_word.wb_en = 1'b1; end
            `OP_SRL:  begin dec_word.exe_cmd = `EXE_SRL; dec_word.wb_en = 1'b1; end
            `OP_ADDI: begin
                dec_word.exe_cmd = `EXE_ADD;
                dec_word.wb_en   = 1'b1;
                dec_word.is_imm  = 1'b1;
            end
            `OP_SUBI: begin
                dec_word.exe_cmd = `EXE_SUB;
                dec_word.wb_en   = 1'b1;
                dec_word.is_imm  = 1'b1;
            end
            `OP_LD: begin
                dec_word.exe_cmd   = `EXE_ADD;
                dec_word.wb_en     = 1'b1;
                dec_word.is_imm    = 1'b1;
                dec_word.st_or_bne = 1'b1;
                dec_word.mem_r_en  = 1'b1;
            end
            `OP_ST: begin
                dec_word.exe_cmd   = `EXE_ADD;
                dec_word.mem_w_en  = 1'b1;
                dec_word.is_imm    = 1'b1;
                dec_word.st_or_bne = 1'b1;
            end
            `OP_BEZ: begin
                dec_word.is_imm    = 1'b1;
                dec_word.br_cmd    = `COND_BEZ;
                dec_word.branch_en = 1'b1;
            end
            `OP_BNE: begin
                dec_word.is_imm    = 1'b1;
                dec_word.br_cmd    = `COND_BNE;
                dec_word.branch_en = 1'b1;
                dec_word.st_or_bne = 1'b1;
            end
            `OP_JMP: begin
                dec_word.is_imm    = 1'b1;
                dec_word.br_cmd    = `COND_JUMP;
                dec_word.branch_en = 1'b1;
            end
            default:  dec_word.illegal = 1'b1;
        endcase
    end

    assign slot_free = !out_valid_q || bus.out_ready;
    assign in_ready  = !skid_valid_q && !bus.hazard_detected && !bus.flush;
    assign accept    = bus.in_valid && in_ready;

    // Priority: flush > skid drain > hazard bubble > accept; a full skid always drains before new input.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.flush) begin
            out_d        = nop_word();
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q && slot_free) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
        end else if (bus.hazard_detected && slot_free) begin
            if (BUBBLE_CLEAR_ALL != 0) begin
                out_d = nop_word();
            end else begin
                out_d.exe_cmd  = `EXE_NO_OPERATION;
                out_d.wb_en    = 1'b0;
                out_d.mem_w_en = 1'b0;
                out_d.illegal  = 1'b0;
            end
            out_valid_d = 1'b1;
            if (bubble_cnt_q != '1) begin
                bubble_cnt_d = bubble_cnt_q + CNT_ONE;
            end
        end else if (accept && slot_free) begin
            out_d       = dec_word;
            out_valid_d = 1'b1;
        end else if (accept) begin
            skid_d       = dec_word;
            skid_valid_d = 1'b1;
        end else if (slot_free) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q        <= nop_word();
            out_valid_q  <= 1'b0;
            skid_q       <= nop_word();
            skid_valid_q <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.branchEn       = out_q.branch_en;
    assign bus.EXE_CMD        = out_q.exe_cmd;
    assign bus.Branch_command = out_q.br_cmd;
    assign bus.Is_Imm         = out_q.is_imm;
    assign bus.ST_or_BNE      = out_q.st_or_bne;
    assign bus.WB_EN          = out_q.wb_en;
    assign bus.MEM_R_EN       = out_q.mem_r_en;
    assign bus.MEM_W_EN       = out_q.mem_w_en;
    assign bus.illegal_op     = out_q.illegal;
    assign bus.bubble_cnt     = bubble_cnt_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage: three instances (default, legacy bubbles, 2-bit counter)
// share one stimulus stream; control words are compared against hand-computed encodings.
`timescale 1ns/1ps
module tb_ctrl_decode_stage;

    `define OBS(i) {i.branchEn, i.EXE_CMD, i.Branch_command, i.Is_Imm, i.ST_or_BNE, i.WB_EN, i.MEM_R_EN, i.MEM_W_EN, i.illegal_op}

    localparam logic [5:0] O_ADD = 6'b000001;
    localparam logic [5:0] O_SUB = 6'b000011;
    localparam logic [5:0] O_OR  = 6'b000110;
    localparam logic [5:0] O_XOR = 6'b001000;
    localparam logic [5:0] O_LD  = 6'b100100;
    localparam logic [5:0] O_ST  = 6'b100101;
    localparam logic [5:0] O_BNE = 6'b101001;
    localparam logic [5:0] O_BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [5:0] opCode = 6'd0;
    logic       hazard = 1'b0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ctrl_decode_stage_if #(.CNT_W(16)) if0 ();
    ctrl_decode_stage_if #(.CNT_W(16)) if1 ();
    ctrl_decode_stage_if #(.CNT_W(2))  if2 ();

    assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
    assign if0.opCode = opCode;      assign if1.opCode = opCode;      assign if2.opCode = opCode;
    assign if0.hazard_detected = hazard;
    assign if1.hazard_detected = hazard;
    assign if2.hazard_detected = hazard;
    assign if0.flush = flush;        assign if1.flush = flush;        assign if2.flush = flush;
    assign if0.out_ready = out_ready;
    assign if1.out_ready = out_ready;
    assign if2.out_ready = out_ready;

    ctrl_decode_stage #(.CNT_W(16), .BUBBLE_CLEAR_ALL(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    ctrl_decode_stage #(.CNT_W(16), .BUBBLE_CLEAR_ALL(0)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    ctrl_decode_stage #(.CNT_W(2),  .BUBBLE_CLEAR_ALL(1)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    function automatic logic [12:0] cw(input logic br, input logic [3:0] exe, input logic [1:0] bc,
                                       input logic imm, input logic sob, input logic wb,
                                       input logic mr, input logic mw, input logic ill);
        return {br, exe, bc, imm, sob, wb, mr, mw, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [12:0] w_nop, w_add, w_sub, w_or, w_xor, w_ld, w_st, w_bne, w_ill, w_ld_legacy;

    initial begin
        w_nop       = cw(0, 4'hF, 2'b00, 0, 0, 0, 0, 0, 0);
        w_add       = cw(0, 4'h0, 2'b00, 0, 0, 1, 0, 0, 0);
        w_sub       = cw(0, 4'h2, 2'b00, 0, 0, 1, 0, 0, 0);
        w_or        = cw(0, 4'h5, 2'b00, 0, 0, 1, 0, 0, 0);
        w_xor       = cw(0, 4'h7, 2'b00, 0, 0, 1, 0, 0, 0);
        w_ld        = cw(0, 4'h0, 2'b00, 1, 1, 1, 1, 0, 0);
        w_st        = cw(0, 4'h0, 2'b00, 1, 1, 0, 0, 1, 0);
        w_bne       = cw(1, 4'hF, 2'b01, 1, 1, 0, 0, 0, 0);
        w_ill       = cw(0, 4'hF, 2'b00, 0, 0, 0, 0, 0, 1);
        w_ld_legacy = cw(0, 4'hF, 2'b00, 1, 1, 0, 1, 0, 0);

        // Reset state
        step(); step();
        chk("reset_out_valid", {31'd0, if0.out_valid}, 32'd0);
        chk("reset_word", {19'd0, `OBS(if0)}, {19'd0, w_nop});
        chk("reset_cnt", {16'd0, if0.bubble_cnt}, 32'd0);
        chk("reset_in_ready", {31'd0, if0.in_ready}, 32'd1);
        rst = 1'b1;
        step();

        // 1: back-to-back ADD, LD, ST
        in_valid = 1'b1; opCode = O_ADD; step();
        chk("t1_add_valid", {31'd0, if0.out_valid}, 32'd1);
        chk("t1_add_word", {19'd0, `OBS(if0)}, {19'd0, w_add});
        opCode = O_LD; step();
        chk("t1_ld_word", {19'd0, `OBS(if0)}, {19'd0, w_ld});
        opCode = O_ST; step();
        chk("t1_st_word", {19'd0, `OBS(if0)}, {19'd0, w_st});
        in_valid = 1'b0; step();
        chk("t1_idle_valid", {31'd0, if0.out_valid}, 32'd0);

        // 2: stall with skid
        out_ready = 1'b0; in_valid = 1'b1; opCode = O_SUB; step();
        chk("t2_sub_word", {19'd0, `OBS(if0)}, {19'd0, w_sub});
        opCode = O_OR; #1;
        chk("t2_ready_before_skid", {31'd0, if0.in_ready}, 32'd1);
        step();
        chk("t2_sub_held", {19'd0, `OBS(if0)}, {19'd0, w_sub});
        opCode = O_XOR; #1;
        chk("t2_ready_skid_full", {31'd0, if0.in_ready}, 32'd0);
        step();
        chk("t2_sub_still_held", {19'd0, `OBS(if0)}, {19'd0, w_sub});
        chk("t2_valid_held", {31'd0, if0.out_valid}, 32'd1);
        out_ready = 1'b1; step();
        chk("t2_or_drained", {19'd0, `OBS(if0)}, {19'd0, w_or});
        chk("t2_ready_after_drain", {31'd0, if0.in_ready}, 32'd1);
        step();
        chk("t2_xor_word", {19'd0, `OBS(if0)}, {19'd0, w_xor});
        in_valid = 1'b0; step();
        chk("t2_idle_valid", {31'd0, if0.out_valid}, 32'd0);

        // 3: two bubbles after LD, pending ST preserved
        in_valid = 1'b1; opCode = O_LD; step();
        chk("t3_ld_word", {19'd0, `OBS(if0)}, {19'd0, w_ld});
        hazard = 1'b1; opCode = O_ST; #1;
        chk("t3_ready_hazard", {31'd0, if0.in_ready}, 32'd0);
        step();
        chk("t3_bubble1_valid", {31'd0, if0.out_valid}, 32'd1);
        chk("t3_bubble1_word", {19'd0, `OBS(if0)}, {19'd0, w_nop});
        chk("t3_legacy_bubble", {19'd0, `OBS(if1)}, {19'd0, w_ld_legacy});
        chk("t3_cnt1", {16'd0, if0.bubble_cnt}, 32'd1);
        step();
        chk("t3_bubble2_word", {19'd0, `OBS(if0)}, {19'd0, w_nop});
        chk("t3_cnt2", {16'd0, if0.bubble_cnt}, 32'd2);
        hazard = 1'b0; step();
        chk("t3_st_not_lost", {19'd0, `OBS(if0)}, {19'd0, w_st});
        chk("t3_st_valid", {31'd0, if0.out_valid}, 32'd1);
        in_valid = 1'b0; step();

        // 4: legacy bubble keeps branch fields
        in_valid = 1'b1; opCode = O_BNE; step();
        chk("t4_bne_word", {19'd0, `OBS(if1)}, {19'd0, w_bne});
        in_valid = 1'b0; hazard = 1'b1; step();
        chk("t4_legacy_bne_kept", {19'd0, `OBS(if1)}, {19'd0, w_bne});
        chk("t4_clear_all_nop", {19'd0, `OBS(if0)}, {19'd0, w_nop});
        chk("t4_cnt3", {16'd0, if0.bubble_cnt}, 32'd3);
        hazard = 1'b0; step();

        // 5: full skid flushed together with hazard
        out_ready = 1'b0; in_valid = 1'b1; opCode = O_ADD; step();
        opCode = O_SUB; step();
        chk("t5_add_held", {19'd0, `OBS(if0)}, {19'd0, w_add});
        flush = 1'b1; hazard = 1'b1; step();
        chk("t5_flush_valid", {31'd0, if0.out_valid}, 32'd0);
        chk("t5_flush_word", {19'd0, `OBS(if0)}, {19'd0, w_nop});
        chk("t5_flush_cnt", {16'd0, if0.bubble_cnt}, 32'd3);
        flush = 1'b0; hazard = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
        chk("t5_skid_empty", {31'd0, if0.in_ready}, 32'd1);
        step();
        chk("t5_no_drain", {31'd0, if0.out_valid}, 32'd0);

        // 5b: hazard while stalled does not count; then saturation
        out_ready = 1'b0; in_valid = 1'b1; opCode = O_ADD; step();
        in_valid = 1'b0; hazard = 1'b1; step();
        chk("t5b_stall_hold", {19'd0, `OBS(if0)}, {19'd0, w_add});
        chk("t5b_stall_cnt", {16'd0, if0.bubble_cnt}, 32'd3);
        out_ready = 1'b1; step(); step();
        chk("t5b_cnt5", {16'd0, if0.bubble_cnt}, 32'd5);
        chk("t5b_cnt_sat", {30'd0, if2.bubble_cnt}, 32'd3);
        hazard = 1'b0; step();

        // 6: illegal opcode, then asynchronous reset mid-stream
        in_valid = 1'b1; opCode = O_BAD; step();
        chk("t6_illegal_word", {19'd0, `OBS(if0)}, {19'd0, w_ill});
        opCode = O_ADD; step();
        chk("t6_add_before_rst", {19'd0, `OBS(if0)}, {19'd0, w_add});
        rst = 1'b0; #1;
        chk("t6_rst_valid", {31'd0, if0.out_valid}, 32'd0);
        chk("t6_rst_word", {19'd0, `OBS(if0)}, {19'd0, w_nop});
        chk("t6_rst_cnt", {16'd0, if0.bubble_cnt}, 32'd0);
        chk("t6_rst_cnt_small", {30'd0, if2.bubble_cnt}, 32'd0);
        in_valid = 1'b0; step();
        rst = 1'b1; step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
